// File: rtl/nco_pkg.sv
// Shared constants and elaboration-time helpers for the quadrature NCO.
// Covers quadrant encoding, quarter-wave table depth and sine table generation.
package nco_pkg;

    localparam logic [1:0] QUAD0 = 2'd0;
    localparam logic [1:0] QUAD1 = 2'd1;
    localparam logic [1:0] QUAD2 = 2'd2;
    localparam logic [1:0] QUAD3 = 2'd3;

    localparam real Pi = 3.14159265358979323846;

    function automatic int unsigned rom_depth(input int unsigned addr_w);
        return 32'd1 << (addr_w - 2);
    endfunction

    // round((2^(out_w-1)-1) * sin(pi/2 * (i+0.5)/depth)) via a Taylor series,
    // evaluated only at elaboration to build the table contents.
    function automatic int unsigned sine_entry(input int unsigned i, input int unsigned depth,
                                               input int unsigned out_w);
        real x;
        real term;
        real s;
        real amp;
        x    = (Pi / 2.0) * (real'(i) + 0.5) / real'(depth);
        term = x;
        s    = x;
        for (int k = 1; k <= 9; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        amp = real'((32'd1 << (out_w - 1)) - 32'd1);
        return unsigned'($rtoi(amp * s + 0.5));
    endfunction

endpackage

// File: rtl/nco_quad_param_qrom.sv
// Registered quarter-wave sine magnitude table with independent sine and cosine read ports.
module nco_qrom
    import nco_pkg::*;
#(
    parameter int unsigned AW    = 6,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    idx_s_i,
    input  logic [AW-1:0]    idx_c_i,
    output logic [OUT_W-2:0] mag_s_o,
    output logic [OUT_W-2:0] mag_c_o
);

    localparam int unsigned Depth = 32'd1 << AW;
    localparam int unsigned MW    = OUT_W - 1;

    logic [MW-1:0] rom [Depth];
    logic [MW-1:0] mag_s_q;
    logic [MW-1:0] mag_c_q;

    for (genvar g = 0; g < Depth; g++) begin : g_rom
        localparam logic [MW-1:0] Val = MW'(sine_entry(g, Depth, OUT_W));
        assign rom[g] = Val;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mag_s_q <= '0;
            mag_c_q <= '0;
        end else begin
            mag_s_q <= rom[idx_s_i];
            mag_c_q <= rom[idx_c_i];
        end
    end

    assign mag_s_o = mag_s_q;
    assign mag_c_o = mag_c_q;

endmodule

// File: rtl/nco_quad_param.sv
// Quadrature NCO: loadable phase accumulator, phase offset, quarter-wave fold and
// sign restore, giving registered signed sine/cosine samples three edges after acc.
module nco_quad_param
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OUT_W  = 8
) (
    input  logic                    clk_top,
    input  logic                    rst_top,
    input  logic                    en,
    input  logic                    fcw_load,
    input  logic [ACC_W-1:0]        fcw_in,
    input  logic [ACC_W-1:0]        phase_in,
    input  logic                    sync_clr,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    out_valid
);

    localparam int unsigned IW = ADDR_W - 2;
    localparam int unsigned MW = OUT_W - 1;
    localparam logic [ADDR_W-1:0] Quarter = ADDR_W'(rom_depth(ADDR_W));

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  fcw_q, off_q;
    logic              v0_q, v1_q, v2_q, valid_q;
    logic [ADDR_W-1:0] addr_s_q, addr_c_q, addr_s_d, addr_c_d;
    logic [IW:0]       fold_s, fold_c;
    logic              neg_s_q, neg_c_q;
    logic [MW-1:0]     mag_s, mag_c;
    logic [OUT_W-1:0]  ext_s, ext_c;
    logic signed [OUT_W-1:0] sin_q, cos_q, sin_d, cos_d;

    // Returns {neg, idx}: odd quadrants mirror the index, upper half negates.
    function automatic logic [IW:0] fold(input logic [ADDR_W-1:0] a);
        logic [IW-1:0] i;
        logic [IW:0]   r;
        i = a[IW-1:0];
        r = '0;
        unique case (a[ADDR_W-1 -: 2])
            QUAD0: r = {1'b0, i};
            QUAD1: r = {1'b0, ~i};
            QUAD2: r = {1'b1, i};
            QUAD3: r = {1'b1, ~i};
        endcase
        return r;
    endfunction

    always_comb begin
        acc_d = acc_q;
        if (sync_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + fcw_q;
        end
    end

    always_comb begin
        addr_s_d = ADDR_W'((acc_q + off_q) >> (ACC_W - ADDR_W));
        addr_c_d = addr_s_d + Quarter;
        fold_s   = fold(addr_s_q);
        fold_c   = fold(addr_c_q);
    end

    nco_qrom #(
        .AW    (IW),
        .OUT_W (OUT_W)
    ) u_qrom (
        .clk_i   (clk_top),
        .rst_i   (rst_top),
        .idx_s_i (fold_s[IW-1:0]),
        .idx_c_i (fold_c[IW-1:0]),
        .mag_s_o (mag_s),
        .mag_c_o (mag_c)
    );

    always_comb begin
        ext_s = {1'b0, mag_s};
        ext_c = {1'b0, mag_c};
        sin_d = neg_s_q ? -ext_s : ext_s;
        cos_d = neg_c_q ? -ext_c : ext_c;
    end

    always_ff @(posedge clk_top or posedge rst_top) begin
        if (rst_top) begin
            acc_q    <= '0;
            fcw_q    <= '0;
            off_q    <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            valid_q  <= 1'b0;
            addr_s_q <= '0;
            addr_c_q <= '0;
            neg_s_q  <= 1'b0;
            neg_c_q  <= 1'b0;
            sin_q    <= '0;
            cos_q    <= '0;
        end else begin
            acc_q <= acc_d;
            if (fcw_load) begin
                fcw_q <= fcw_in;
                off_q <= phase_in;
            end
            v0_q     <= en;
            addr_s_q <= addr_s_d;
            addr_c_q <= addr_c_d;
            v1_q     <= v0_q;
            neg_s_q  <= fold_s[IW];
            neg_c_q  <= fold_c[IW];
            v2_q     <= v1_q;
            sin_q    <= sin_d;
            cos_q    <= cos_d;
            valid_q  <= v2_q;
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = valid_q;

endmodule
